// File: rtl/uart_tx_if.sv
// Transmit-side handshake between the processor I/O write path and uart_tx.
interface uart_tx_if;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       tx_out;
  logic       tx_busy;
  logic       tx_done;

  // Processor side: requests a byte, watches the line status.
  modport master (output tx_start, tx_byte, input tx_out, tx_busy, tx_done);
  // Transmitter side.
  modport slave  (input tx_start, tx_byte, output tx_out, tx_busy, tx_done);
endinterface

// File: rtl/uart_tx.sv
// 8N1 serial transmitter: start bit, 8 data bits LSB first, stop bit.
// Each bit is held for CLOCKS_PER_BIT cycles; all outputs are registered.
module uart_tx #(
  parameter int CLOCKS_PER_BIT = 50
) (
  input logic       clk,
  input logic       rst,
  uart_tx_if.slave  tx_if
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [31:0] LAST = 32'(CLOCKS_PER_BIT - 1);

  logic [1:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shr_q, shr_d;
  logic        tx_out_q, tx_out_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        bit_end;
  assign bit_end = (cnt_q == LAST);

  // Next-state logic; tx_done defaults low so it is a single-cycle pulse.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shr_d    = shr_q;
    tx_out_d = tx_out_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        tx_out_d = 1'b1;
        if (tx_if.tx_start) begin
          shr_d    = tx_if.tx_byte;
          tx_out_d = 1'b0;
          busy_d   = 1'b1;
          cnt_d    = '0;
          idx_d    = '0;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d    = '0;
          tx_out_d = shr_q[0];
          state_d  = DATA;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q != 3'd7) begin
            idx_d    = idx_q + 3'd1;
            tx_out_d = shr_q[idx_q + 3'd1];
          end else begin
            idx_d    = '0;
            tx_out_d = 1'b1;
            state_d  = STOP;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        tx_out_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State registers; reset forces the line idle-high immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shr_q    <= '0;
      tx_out_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shr_q    <= shr_d;
      tx_out_q <= tx_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign tx_if.tx_out  = tx_out_q;
  assign tx_if.tx_busy = busy_q;
  assign tx_if.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: CPB=4 instance for timing checks,
// CPB=50 instance decoded by a behavioural receiver for loopback.
module tb_uart_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total = 0;

  always #5 clk = ~clk;

  uart_tx_if b4 ();
  uart_tx_if b50 ();

  uart_tx #(.CLOCKS_PER_BIT(4))  dut4  (.clk(clk), .rst(rst), .tx_if(b4.slave));
  uart_tx #(.CLOCKS_PER_BIT(50)) dut50 (.clk(clk), .rst(rst), .tx_if(b50.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one byte on the CPB=4 instance and records the line at mid-bit,
  // the busy cycle count and the tx_done pulses. inject_t >= 0 pulses
  // tx_start with 0xFF at that cycle offset from the accepting edge.
  task automatic send_capture(input logic [7:0] b, input int inject_t, input int span,
                              output logic [9:0] frame, output int busy, output int done,
                              output int done_t);
    frame = '0; busy = 0; done = 0; done_t = -1;
    b4.tx_byte = b; b4.tx_start = 1'b1;
    tick();
    b4.tx_start = 1'b0;
    for (int t = 0; t < span; t++) begin
      if (t > 0) tick();
      if (t == inject_t) begin b4.tx_byte = 8'hFF; b4.tx_start = 1'b1; end
      if (t == inject_t + 1) b4.tx_start = 1'b0;
      if (b4.tx_busy === 1'b1) busy++;
      if (b4.tx_done === 1'b1) begin done++; done_t = t; end
      if (t % 4 == 2 && t < 40) frame[t/4] = b4.tx_out;
    end
  endtask

  task automatic test_reset();
    logic [9:0] f; int bz, dn, dt;
    rst = 1'b1;
    b4.tx_start = 1'b0; b4.tx_byte = 8'h00;
    b50.tx_start = 1'b0; b50.tx_byte = 8'h00;
    repeat (3) tick();
    total++; if (b4.tx_out !== 1'b1) $display("FAIL rst_out got %b want 1", b4.tx_out); else pass_cnt++;
    total++; if (b4.tx_busy !== 1'b0) $display("FAIL rst_busy got %b want 0", b4.tx_busy); else pass_cnt++;
    total++; if (b4.tx_done !== 1'b0) $display("FAIL rst_done got %b want 0", b4.tx_done); else pass_cnt++;
    rst = 1'b0;
    tick();
    // Start a frame and hit reset during the first data bit (line low).
    send_capture(8'h00, -1, 7, f, bz, dn, dt);
    rst = 1'b1;
    #1;
    total++; if (b4.tx_out !== 1'b1) $display("FAIL async_rst_out got %b want 1", b4.tx_out); else pass_cnt++;
    total++; if (b4.tx_busy !== 1'b0) $display("FAIL async_rst_busy got %b want 0", b4.tx_busy); else pass_cnt++;
    total++; if (b4.tx_done !== 1'b0) $display("FAIL async_rst_done got %b want 0", b4.tx_done); else pass_cnt++;
    tick();
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_single();
    logic [9:0] f; int bz, dn, dt;
    send_capture(8'hA5, -1, 45, f, bz, dn, dt);
    total++; if (f !== 10'b1101001010) $display("FAIL single_frame got %b want 1101001010", f); else pass_cnt++;
    total++; if (bz != 40) $display("FAIL single_busy_cycles got %0d want 40", bz); else pass_cnt++;
    total++; if (dn != 1) $display("FAIL single_done_count got %0d want 1", dn); else pass_cnt++;
    total++; if (dt != 40) $display("FAIL single_done_time got %0d want 40", dt); else pass_cnt++;
  endtask

  task automatic test_busy_lockout();
    logic [9:0] f; int bz, dn, dt;
    send_capture(8'h3C, 12, 100, f, bz, dn, dt);
    total++; if (f !== 10'b1001111000) $display("FAIL lockout_frame got %b want 1001111000", f); else pass_cnt++;
    total++; if (bz != 40) $display("FAIL lockout_busy_cycles got %0d want 40", bz); else pass_cnt++;
    total++; if (dn != 1) $display("FAIL lockout_done_count got %0d want 1", dn); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [9:0] f1, f2; int dn;
    f1 = '0; f2 = '0; dn = 0;
    b4.tx_byte = 8'h00; b4.tx_start = 1'b1;
    tick();
    for (int t = 0; t < 90; t++) begin
      if (t > 0) tick();
      if (b4.tx_done === 1'b1) dn++;
      if (t == 40) begin
        total++; if (b4.tx_out !== 1'b1) $display("FAIL b2b_gap_line got %b want 1", b4.tx_out); else pass_cnt++;
        total++; if (b4.tx_done !== 1'b1) $display("FAIL b2b_gap_done got %b want 1", b4.tx_done); else pass_cnt++;
        b4.tx_byte = 8'hFF;
      end
      if (t == 41) begin
        total++; if (b4.tx_out !== 1'b0) $display("FAIL b2b_second_start got %b want 0", b4.tx_out); else pass_cnt++;
        total++; if (b4.tx_busy !== 1'b1) $display("FAIL b2b_second_busy got %b want 1", b4.tx_busy); else pass_cnt++;
      end
      if (t == 42) b4.tx_start = 1'b0;
      if (t % 4 == 2 && t < 40) f1[t/4] = b4.tx_out;
      if (t >= 41 && t < 81 && (t - 41) % 4 == 2) f2[(t-41)/4] = b4.tx_out;
    end
    total++; if (f1 !== 10'b1000000000) $display("FAIL b2b_frame1 got %b want 1000000000", f1); else pass_cnt++;
    total++; if (f2 !== 10'b1111111110) $display("FAIL b2b_frame2 got %b want 1111111110", f2); else pass_cnt++;
    total++; if (dn != 2) $display("FAIL b2b_done_count got %0d want 2", dn); else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    logic [9:0] f; int bz, dn, dt, hi;
    send_capture(8'h00, -1, 18, f, bz, dn, dt);
    rst = 1'b1;
    #1;
    total++; if (b4.tx_out !== 1'b1) $display("FAIL mid_rst_out got %b want 1", b4.tx_out); else pass_cnt++;
    total++; if (b4.tx_busy !== 1'b0) $display("FAIL mid_rst_busy got %b want 0", b4.tx_busy); else pass_cnt++;
    dn = 0; hi = 0;
    repeat (2) begin tick(); if (b4.tx_done === 1'b1) dn++; if (b4.tx_out === 1'b1) hi++; end
    rst = 1'b0;
    repeat (30) begin tick(); if (b4.tx_done === 1'b1) dn++; if (b4.tx_out === 1'b1) hi++; end
    total++; if (dn != 0) $display("FAIL mid_rst_no_done got %0d want 0", dn); else pass_cnt++;
    total++; if (hi != 32) $display("FAIL mid_rst_idle_high got %0d want 32", hi); else pass_cnt++;
    send_capture(8'h81, -1, 45, f, bz, dn, dt);
    total++; if (f !== 10'b1100000010) $display("FAIL mid_rst_next_frame got %b want 1100000010", f); else pass_cnt++;
    total++; if (dn != 1) $display("FAIL mid_rst_next_done got %0d want 1", dn); else pass_cnt++;
  endtask

  task automatic test_loopback();
    logic [7:0] vec [4];
    logic [7:0] d;
    logic s0, sp;
    int n, rxd, dn;
    vec[0] = 8'h00; vec[1] = 8'h55; vec[2] = 8'hAA; vec[3] = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      b50.tx_byte = vec[i]; b50.tx_start = 1'b1;
      tick();
      b50.tx_start = 1'b0;
      n = 0;
      while (b50.tx_out !== 1'b0 && n < 200) begin tick(); n++; end
      if (n >= 200) begin
        total++; $display("FAIL loop_start_timeout byte %0d got no start bit want start", i);
      end
      repeat (24) tick();
      s0 = b50.tx_out;
      d = '0;
      for (int j = 0; j < 8; j++) begin repeat (50) tick(); d[j] = b50.tx_out; end
      repeat (50) tick();
      sp = b50.tx_out;
      rxd = (s0 === 1'b0 && sp === 1'b1) ? 1 : 0;
      dn = 0;
      repeat (60) begin tick(); if (b50.tx_done === 1'b1) dn++; end
      total++; if (d !== vec[i]) $display("FAIL loop_byte got %h want %h", d, vec[i]); else pass_cnt++;
      total++; if (rxd != 1) $display("FAIL loop_rx_done got %0d want 1", rxd); else pass_cnt++;
      total++; if (dn != 1) $display("FAIL loop_tx_done got %0d want 1", dn); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_busy_lockout();
    test_back_to_back();
    test_reset_midframe();
    test_loopback();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter: takes a parallel byte from the processor's I/O side and sends it on a single line as an 8N1 frame. The frame is 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1). It is the transmit-side companion of the processor's UART receive path, uses the same bit-period parameter so both ends agree on baud, and is driven by the I/O write path of the processor.

## Interface
Parameters:
- CLOCKS_PER_BIT, default 50: clock cycles per serial bit. For 100 MHz: 10417 gives 9600 baud, 868 gives 115200. Legal range is ≥2.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- tx_start  input  1  request to send tx_byte; sampled only in IDLE.
- tx_byte  input  8  byte to send; captured on the accepting edge.
- tx_out  output  1  serial line; idle level 1.
- tx_busy  output  1  high from the accepting edge until the frame ends.
- tx_done  output  1  one-cycle pulse at the end of each frame.

## Operation
- All outputs are registered. While rst is high:
  - tx_out=1, tx_busy=0, tx_done=0.
  - State is IDLE; bit counter and index are 0; the shift register is 0.
- States: IDLE, START, DATA, STOP. Any unused encoding goes to IDLE on the next edge.
- IDLE:
  - tx_out=1 and tx_done is cleared, except when tx_done was set on the edge that entered IDLE, in which case it stays high for that one cycle.
  - If tx_start=1 at an edge: latch tx_byte into the shift register, tx_out<=0, tx_busy<=1, clock_count<=0, bit index<=0, state<=START.
- START: hold tx_out=0 for CLOCKS_PER_BIT cycles. At clock_count==CLOCKS_PER_BIT-1: clock_count<=0, tx_out<=data[0], state<=DATA.
- DATA: hold each bit for CLOCKS_PER_BIT cycles. At clock_count==CLOCKS_PER_BIT-1:
  - If index<7: index+1, tx_out<=data[index+1].
  - If index==7: index<=0, tx_out<=1, state<=STOP.
- STOP: hold tx_out=1 for CLOCKS_PER_BIT cycles. At clock_count==CLOCKS_PER_BIT-1: tx_busy<=0, tx_done<=1, clock_count<=0, state<=IDLE.
- tx_done is high for exactly one cycle per frame.
- tx_start and tx_byte are ignored in START/DATA/STOP. Changing tx_byte mid-frame has no effect on the frame in flight.
- clock_count is wide enough for CLOCKS_PER_BIT-1 (32 bits). It never wraps, because it is reset at every bit boundary.
- Reset mid-frame: tx_out returns to 1 immediately (asynchronously). The partial frame is abandoned and no tx_done is produced.

## Timing
- Let E0 be the accepting edge. tx_out is driven from E0 to E0+10·CLOCKS_PER_BIT, with bit k on the line during [E0+k·CPB, E0+(k+1)·CPB):
  - k=0: start bit.
  - k=1..8: data[0..7].
  - k=9: stop bit.
- At edge E0+10·CPB: tx_busy falls and tx_done rises. tx_done falls at E0+10·CPB+1.
- Earliest next accept is edge E0+10·CPB+1. A tx_start held continuously high therefore sends back-to-back frames with exactly one extra idle-high cycle between them.
- A tx_start asserted in the cycle tx_done is high is accepted at that edge, because the block is already in IDLE.
- tx_start asserted for a single cycle in IDLE is sufficient; no hold is required.
- Latency from tx_start sampled to start bit on the line is 0 cycles after the accepting edge.

## Test plan
- Reset check (CPB=4): assert rst mid-simulation → tx_out=1, tx_busy=0, tx_done=0 within the same cycle, before any clock edge.
- Single byte (CPB=4): pulse tx_start with tx_byte=0xA5 → the line sampled mid-bit reads 0,1,0,1,0,0,1,0,1,1. tx_busy is high for exactly 40 cycles; tx_done is high for 1 cycle at E0+40.
- Busy lockout (CPB=4): send 0x3C, then pulse tx_start with tx_byte=0xFF at E0+12 → the line carries only 0x3C. No second frame occurs and exactly one tx_done pulse is seen.
- Back-to-back (CPB=4): hold tx_start=1 and present 0x00, then 0xFF on the edge after tx_done → the second start bit begins at E0+41. The line is 1 during cycle E0+40, and the second frame decodes as 0xFF.
- Reset mid-frame (CPB=4): assert rst at E0+17 for 2 cycles, then send 0x81 → tx_out=1 during reset and no tx_done for the aborted frame. The following frame decodes as 0x81.
- Loopback (CPB=50): tx_out feeds the team's UART receiver with the same CPB; send 0x00, 0x55, 0xAA, 0xFF → the receiver reports each byte exactly, with one rx_done per frame.
